// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time
// a single JK command against a bank of NBITS flops.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [2*NREQ-1:0]            cmd,
  input  logic [$clog2(NBITS)*NREQ-1:0] idx,
  output logic [NREQ-1:0]              gnt,
  output logic [NBITS-1:0]             q,
  output logic [NBITS-1:0]             qb,
  output logic                         busy
);

  localparam int PW = $clog2(NREQ);
  localparam int IW = $clog2(NBITS);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   win, win_d;
  logic [1:0]      lat_cmd, lat_cmd_d;
  logic [IW-1:0]   lat_idx, lat_idx_d;
  logic [NREQ-1:0] gnt_d;
  logic [NBITS-1:0] q_d;

  logic            found;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   sel;
  logic [1:0]      sel_cmd;
  logic [IW-1:0]   sel_idx;

  // first active requester at or after ptr, wrapping
  always_comb begin
    found   = 1'b0;
    cand    = ptr;
    sel     = ptr;
    sel_cmd = '0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + PW'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        sel     = cand;
        sel_cmd = cmd[2*int'(cand) +: 2];
        sel_idx = idx[IW*int'(cand) +: IW];
      end
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    win_d     = win;
    lat_cmd_d = lat_cmd;
    lat_idx_d = lat_idx;
    gnt_d     = '0;
    q_d       = q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d    = APPLY;
          win_d      = sel;
          lat_cmd_d  = sel_cmd;
          lat_idx_d  = sel_idx;
          gnt_d[sel] = 1'b1;
        end
      end
      APPLY: begin
        state_d = IDLE;
        ptr_d   = win + PW'(1);
        unique case (lat_cmd)
          2'b00: q_d[lat_idx] = q[lat_idx];
          2'b01: q_d[lat_idx] = 1'b0;
          2'b10: q_d[lat_idx] = 1'b1;
          2'b11: q_d[lat_idx] = ~q[lat_idx];
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      lat_cmd <= '0;
      lat_idx <= '0;
      gnt     <= '0;
      q       <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      win     <= win_d;
      lat_cmd <= lat_cmd_d;
      lat_idx <= lat_idx_d;
      gnt     <= gnt_d;
      q       <= q_d;
    end
  end

  assign qb   = ~q;
  assign busy = (state == APPLY);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [11:0] idx;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qb;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  // reference model state
  bit       m_busy = 1'b0;
  int       m_ptr  = 0;
  int       m_win  = 0;
  bit [1:0] m_cmd  = 2'b00;
  int       m_idx  = 0;
  bit [7:0] m_q    = 8'h00;
  bit [3:0] m_gnt  = 4'h0;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .idx  (idx),
    .gnt  (gnt),
    .q    (q),
    .qb   (qb),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // model advances on the same edge as the DUT
  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_q    = 8'h00;
      m_gnt  = 4'h0;
    end else if (m_busy) begin
      case (m_cmd)
        2'b01: m_q[m_idx] = 1'b0;
        2'b10: m_q[m_idx] = 1'b1;
        2'b11: m_q[m_idx] = ~m_q[m_idx];
        default: ;
      endcase
      m_ptr  = (m_win + 1) % 4;
      m_busy = 1'b0;
      m_gnt  = 4'h0;
    end else if (req != 4'h0) begin
      for (int k = 0; k < 4; k++) begin
        int w;
        w = (m_ptr + k) % 4;
        if (!m_busy && req[w]) begin
          m_busy = 1'b1;
          m_win  = w;
          m_cmd  = cmd[2*w +: 2];
          m_idx  = int'(idx[3*w +: 3]);
          m_gnt  = 4'h0;
          m_gnt[w] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("gnt", {4'h0, gnt}, {4'h0, m_gnt});
      chk("q", q, m_q);
      chk("qb_inv", qb, ~q);
      chk("busy", {7'h0, busy}, {7'h0, m_busy});
      chk("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'h0;
    tick();
    rst = 1'b1;
  endtask

  // one command from requester r, then idle until applied
  task automatic one(input int r, input bit [1:0] c, input bit [2:0] i);
    req = 4'h0;
    req[r] = 1'b1;
    cmd[2*r +: 2] = c;
    idx[3*r +: 3] = i;
    tick();
    req = 4'h0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req = 4'h0;
    cmd = 8'h00;
    idx = 12'h000;
    tick();
    tick();
    run = 1'b1;
    chk("rst_gnt", {4'h0, gnt}, 8'h00);
    chk("rst_q", q, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_busy", {7'h0, busy}, 8'h00);
    rst = 1'b1;

    // set idx 3 from requester 0
    req = 4'b0001;
    cmd = 8'b0000_0010;
    idx = 12'd3;
    tick();
    chk("r29_gnt", {4'h0, gnt}, 8'h01);
    req = 4'h0;
    tick();
    chk("r29_gnt_low", {4'h0, gnt}, 8'h00);
    chk("r29_q", q, 8'h08);
    chk("r29_qb", qb, 8'hF7);
    chk("r29_model", m_q, 8'h08);

    // toggle idx 3, change inputs mid-APPLY, then set idx 0
    req = 4'b0100;
    cmd = 8'b0011_0000;
    idx = 12'b000_011_000_000;
    tick();
    chk("r30_gnt1", {4'h0, gnt}, 8'h04);
    cmd = 8'b0010_0000;
    idx = 12'b000_000_000_000;
    tick();
    chk("r30_q1", q, 8'h00);
    tick();
    chk("r30_gnt2", {4'h0, gnt}, 8'h04);
    req = 4'h0;
    tick();
    chk("r30_q2", q, 8'h01);

    // all four requesting, toggles on distinct indices
    do_reset();
    req = 4'b1111;
    cmd = 8'hFF;
    idx = 12'b011_010_001_000;
    for (int i = 0; i < 5; i++) begin
      bit [3:0] e;
      e = 4'b0001 << (i % 4);
      tick();
      chk($sformatf("r31_gnt%0d", i), {4'h0, gnt}, {4'h0, e});
      tick();
      if (i == 3) chk("r31_q", q, 8'h0F);
    end
    req = 4'h0;

    // requesters 0 and 2 alternate
    do_reset();
    req = 4'b0101;
    cmd = 8'h00;
    for (int i = 0; i < 4; i++) begin
      bit [3:0] e;
      e = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      tick();
      chk($sformatf("r32_gnt%0d", i), {4'h0, gnt}, {4'h0, e});
      tick();
    end
    req = 4'h0;

    // reset during APPLY aborts the pending set
    do_reset();
    req = 4'b0001;
    cmd = 8'b0000_0010;
    idx = 12'd7;
    tick();
    chk("r33_gnt", {4'h0, gnt}, 8'h01);
    rst = 1'b0;
    req = 4'h0;
    tick();
    chk("r33_q", q, 8'h00);
    chk("r33_busy", {7'h0, busy}, 8'h00);
    rst = 1'b1;
    tick();
    chk("r33_q_after", q, 8'h00);

    // build A5, hold then clear bit 5
    do_reset();
    one(0, 2'b10, 3'd0);
    one(1, 2'b10, 3'd2);
    one(2, 2'b10, 3'd5);
    one(3, 2'b10, 3'd7);
    chk("r34_a5", q, 8'hA5);
    chk("r34_model", m_q, 8'hA5);
    one(1, 2'b00, 3'd5);
    chk("r34_hold", q, 8'hA5);
    one(2, 2'b01, 3'd5);
    chk("r34_clr", q, 8'h85);

    // random traffic, occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      req = 4'($urandom);
      cmd = 8'($urandom);
      idx = 12'($urandom);
      tick();
    end
    rst = 1'b1;
    req = 4'h0;
    tick();
    tick();
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
